// File: rtl/dump_pkg.sv
// dump_pkg
// Shared definitions for the RAM dump reader: RAM geometry, the FSM state
// encoding, the word-count width and a helper that turns an inclusive,
// wrap-around address range into a word count.
package dump_pkg;

   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 16;
   localparam int CNT_W   = ADDR_W + 1;
   localparam int ENTRY_W = ADDR_W + DATA_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // The subtraction wraps modulo 2^ADDR_W, so last = first - 1 yields the
   // full RAM (2^ADDR_W words), which is why the count needs one extra bit.
   function automatic logic [CNT_W-1:0] range_count(input logic [ADDR_W-1:0] first,
                                                    input logic [ADDR_W-1:0] last);
      logic [ADDR_W-1:0] span;
      span = last - first;
      return {1'b0, span} + CNT_W'(1);
   endfunction

endpackage

// File: rtl/ram_dump_reader_if.sv
// ram_dump_reader_if
// Bundles every non-clock/reset signal of the dump reader.
//   control : start, abort, first_addr, last_addr -> ; busy, done <-
//   RAM     : ram_rd, ram_raddr ->                 ; ram_rdata <-
//   stream  : out_valid, out_data, out_addr ->     ; out_ready <-
// The master modport is the dump reader itself; the slave modport is the
// host/bench side that also models the RAM read port.
interface ram_dump_reader_if;
   import dump_pkg::*;

   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] first_addr;
   logic [ADDR_W-1:0] last_addr;
   logic              busy;
   logic              done;
   logic              ram_rd;
   logic [ADDR_W-1:0] ram_raddr;
   logic [DATA_W-1:0] ram_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;

   modport master (
      input  start, abort, first_addr, last_addr, ram_rdata, out_ready,
      output busy, done, ram_rd, ram_raddr, out_valid, out_data, out_addr
   );

   modport slave (
      output start, abort, first_addr, last_addr, ram_rdata, out_ready,
      input  busy, done, ram_rd, ram_raddr, out_valid, out_data, out_addr
   );

endinterface

// File: rtl/dump_fifo2.sv
// dump_fifo2
// Two-entry register FIFO holding {address, data} pairs returned by the RAM.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   push, din     : write an entry
//   pop           : drop the head entry (only while non-empty)
//   flush         : empty the FIFO, overriding push/pop
//   dout          : head entry (entry 0)
//   occ           : number of valid entries, 0..2
module dump_fifo2
   import dump_pkg::*;
#(
   parameter int W = ENTRY_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   occ
);

   logic [W-1:0] ent0_q, ent0_d;
   logic [W-1:0] ent1_q, ent1_d;
   logic [1:0]   occ_q, occ_d;

   // Entry 0 is always the head, so a pop shifts entry 1 forward. A
   // simultaneous push and pop keeps occupancy and refills the tail slot.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      if (flush) begin
         occ_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ_q == 2'd0) ent0_d = din;
               else               ent1_d = din;
               occ_d = occ_q + 2'd1;
            end
            2'b01: begin
               ent0_d = ent1_q;
               occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd2) begin
                  ent0_d = ent1_q;
                  ent1_d = din;
               end else begin
                  ent0_d = din;
               end
            end
            default: ;
         endcase
      end
   end

   // Entry storage and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent0_q <= '0;
         ent1_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         occ_q  <= occ_d;
      end
   end

   assign dout = ent0_q;
   assign occ  = occ_q;

   // The issue throttle upstream guarantees there is always room.
   overflow_chk: assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && !flush && occ_q == 2'd2));

   underflow_chk: assert property (@(posedge clk) disable iff (!rst)
      !(pop && !flush && occ_q == 2'd0));

endmodule

// File: rtl/ram_dump_reader.sv
// ram_dump_reader
// Sweeps an inclusive, wrap-around address range of the data RAM through a
// dedicated read port and streams each word with its address on a
// valid/ready output.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : ram_dump_reader_if.master (control, RAM read port, output stream)
module ram_dump_reader
   import dump_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   ram_dump_reader_if.master   bus
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  remain_q, remain_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] land_addr_q, land_addr_d;
   logic              done_q, done_d;

   logic              out_valid;
   logic              pop;
   logic              issue;
   logic              flush;
   logic [2:0]        level;
   logic [1:0]        occ;
   logic [ENTRY_W-1:0] fifo_dout;

   assign out_valid = (occ != 2'd0);
   assign pop       = out_valid && bus.out_ready;
   assign flush     = bus.abort && (state_q != IDLE);

   // level counts words already committed to the FIFO after this cycle's
   // pop: stored entries plus the read landing now. A new read may go out
   // only if its data will find a free slot when it lands next cycle.
   always_comb begin
      level = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
      issue = (state_q == RUN) && !bus.abort && (level < 3'd2);
   end

   // Sweep control. abort wins over everything and returns to IDLE without
   // a done pulse; DRAIN finishes on the pop of the very last word.
   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      remain_d    = remain_q;
      done_d      = 1'b0;
      inflight_d  = issue;
      land_addr_d = rd_ptr_q;
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d  = RUN;
               rd_ptr_d = bus.first_addr;
               remain_d = range_count(bus.first_addr, bus.last_addr);
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (issue) begin
               rd_ptr_d = rd_ptr_q + ADDR_W'(1);
               remain_d = remain_q - CNT_W'(1);
               if (remain_q == CNT_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (!inflight_q && occ == 2'd1 && pop) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rd_ptr_q    <= '0;
         remain_q    <= '0;
         inflight_q  <= 1'b0;
         land_addr_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         remain_q    <= remain_d;
         inflight_q  <= inflight_d;
         land_addr_q <= land_addr_d;
         done_q      <= done_d;
      end
   end

   // Returning RAM data is paired with the address it was read from; the
   // flush on abort also discards a word landing in the abort cycle.
   dump_fifo2 #(.W(ENTRY_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight_q),
      .pop   (pop),
      .flush (flush),
      .din   ({land_addr_q, bus.ram_rdata}),
      .dout  (fifo_dout),
      .occ   (occ)
   );

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.ram_rd    = issue;
   assign bus.ram_raddr = rd_ptr_q;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = fifo_dout[DATA_W-1:0];
   assign bus.out_addr  = fifo_dout[ENTRY_W-1:DATA_W];

endmodule
